store_merge_rmw: RTL

Store-path counterpart of the load extension logic. Takes byte, halfword and word store requests from the core and writes them into a 32-bit word-addressed data memory. Sub-word stores use a read-modify-write sequence: read the word, replace the addressed lane(s), write it back. Word stores write directly. Sits between the core's store interface and the synchronous data RAM port.

---
 rtl/store_merge_rmw.sv | 135 +++++++++++++
 1 files changed

// File: rtl/store_merge_rmw.sv
// Store path: sub-word stores read-modify-write a word RAM; word stores write directly.
// Optional STORE_ALIGN_CHK_EN rejects misaligned half/word stores with an err pulse.
module store_merge_rmw #(
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WT,
        MG,
        WR
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;
    logic [1:0]        size_q;
    logic [31:0]       wdata_q;
    logic [31:0]       merged;
    logic              done_q;
    logic              err_q;
    logic              accept;
    logic              sub;
    logic              mis;

    assign accept = req_valid & req_ready;
    assign sub    = ~req_size[1];

`ifdef STORE_ALIGN_CHK_EN
    assign mis = ((req_size == 2'b01) & req_addr[0]) |
                 (req_size[1] & (|req_addr[1:0]));
`else
    assign mis = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid && !mis) begin
                    state_nx = sub ? RD : WR;
                end
            end
            RD: begin
                mem_en   = 1'b1;
                state_nx = (RD_LAT == 2) ? WT : MG;
            end
            WT: state_nx = MG;
            MG: state_nx = WR;
            WR: begin
                mem_en   = 1'b1;
                mem_we   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Lane replacement over the word fetched from RAM
    always_comb begin
        merged = mem_rdata;
        unique case (size_q)
            2'b00: merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
            2'b01: begin
                if (addr_q[1]) begin
                    merged[31:16] = data_q[15:0];
                end else begin
                    merged[15:0] = data_q[15:0];
                end
            end
            default: merged = data_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            data_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q <= req_addr;
                data_q <= req_data;
                size_q <= req_size;
                if (!sub) begin
                    wdata_q <= req_data;
                end
            end
            if (state == MG) begin
                wdata_q <= merged;
            end
            done_q <= (state == WR);
            err_q  <= accept & mis;
        end
    end

    assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wdata = wdata_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
